// File: rtl/layer_compositor.sv
// layer_compositor
//
// Per-pixel layer compositor for the VGA path. Among NUM_LAYERS drawing
// objects it selects the highest-index layer that requests the pixel, is not
// colour-keyed and is not hidden by the frame-synchronous blink. If no layer
// qualifies, the background colour is used. The RGB332 result is expanded to
// 8-bit R/G/B channels. Fixed two-register latency and no stalls.
//
// Parameters:
//   NUM_LAYERS   number of object layers (index NUM_LAYERS-1 = top priority)
//   TRANSPARENT  RGB332 colour key meaning "not drawn"
//   BLINK_FRAMES frames per blink half-period
//   REPLICATE    0 = zero-pad channel LSBs, 1 = replicate MSBs into LSBs
//
// Ports:
//   CLK, RESET         pixel clock, synchronous active-high reset
//   pixel_valid        pixel lies in the active display area
//   start_of_frame     one-cycle pulse at frame start
//   draw_req           per-layer draw request
//   layer_rgb          per-layer RGB332, layer i in bits [8i+7:8i]
//   blink_en           per-layer blink enable
//   background_rgb     background RGB332 (never keyed)
//   m_mVGA_R/G/B       expanded 8-bit colour channels
//   out_valid          pixel_valid delayed to match the colour outputs
//   out_layer          winning layer index, NUM_LAYERS = background/blank
//   blink_phase        0 = blinking layers shown, 1 = hidden
module layer_compositor #(
  parameter int         NUM_LAYERS   = 5,
  parameter logic [7:0] TRANSPARENT  = 8'hFF,
  parameter int         BLINK_FRAMES = 16,
  parameter bit         REPLICATE    = 1'b0
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                pixel_valid,
  input  logic                                start_of_frame,
  input  logic [NUM_LAYERS-1:0]               draw_req,
  input  logic [8*NUM_LAYERS-1:0]             layer_rgb,
  input  logic [NUM_LAYERS-1:0]               blink_en,
  input  logic [7:0]                          background_rgb,
  output logic [7:0]                          m_mVGA_R,
  output logic [7:0]                          m_mVGA_G,
  output logic [7:0]                          m_mVGA_B,
  output logic                                out_valid,
  output logic [$clog2(NUM_LAYERS+1)-1:0]     out_layer,
  output logic                                blink_phase
);

  localparam int LW = $clog2(NUM_LAYERS + 1);
  localparam int CW = $clog2(BLINK_FRAMES) + 1;

  // ---------------------------------------------------------------------------
  // Blink counter: counts frame starts, toggles the phase every BLINK_FRAMES.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] blink_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (start_of_frame) begin
      if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Candidate qualification and priority selection.
  // The registered blink_phase is used here, so a toggle caused by a
  // start_of_frame pulse only affects pixels sampled on later edges.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] cand;
  logic [7:0]            sel_c;
  logic [LW-1:0]         sel_idx;

  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      cand[i] = draw_req[i]
             && (layer_rgb[8*i +: 8] != TRANSPARENT)
             && !(blink_en[i] && blink_phase);
    end
  end

  always_comb begin
    sel_c   = background_rgb;
    sel_idx = LW'(NUM_LAYERS);
    // Ascending scan: a later (higher-index) candidate overrides earlier ones.
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (cand[i]) begin
        sel_c   = layer_rgb[8*i +: 8];
        sel_idx = LW'(i);
      end
    end
    // Blanking: outside the active area the colour is black and the index
    // reports the background slot, regardless of requests.
    if (!pixel_valid) begin
      sel_c   = '0;
      sel_idx = LW'(NUM_LAYERS);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: selected colour, index and valid.
  // ---------------------------------------------------------------------------
  logic [7:0]    s1_c;
  logic [LW-1:0] s1_idx;
  logic          s1_valid;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_c     <= '0;
      s1_idx   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_c     <= sel_c;
      s1_idx   <= sel_idx;
      s1_valid <= pixel_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // RGB332 to 8-bit channel expansion.
  // ---------------------------------------------------------------------------
  logic [7:0] exp_r;
  logic [7:0] exp_g;
  logic [7:0] exp_b;

  generate
    if (REPLICATE) begin : g_replicate
      always_comb begin
        exp_r = {s1_c[7:5], s1_c[7:5], s1_c[7:6]};
        exp_g = {s1_c[4:2], s1_c[4:2], s1_c[4:3]};
        exp_b = {s1_c[1:0], s1_c[1:0], s1_c[1:0], s1_c[1:0]};
      end
    end else begin : g_zero_pad
      always_comb begin
        exp_r = {s1_c[7:5], 5'b0};
        exp_g = {s1_c[4:2], 5'b0};
        exp_b = {s1_c[1:0], 6'b0};
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 2: expanded channels, layer index and valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      m_mVGA_R  <= '0;
      m_mVGA_G  <= '0;
      m_mVGA_B  <= '0;
      out_layer <= '0;
      out_valid <= 1'b0;
    end else begin
      m_mVGA_R  <= exp_r;
      m_mVGA_G  <= exp_g;
      m_mVGA_B  <= exp_b;
      out_layer <= s1_idx;
      out_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor. Two instances share every input:
// one zero-pads the channel expansion, the other replicates MSBs. Both use a
// two-frame blink half-period. The driver pushes one hand-computed expectation
// per cycle; the monitor pops one per falling edge and compares both outputs.
module tb_layer_compositor;

  localparam int NL = 5;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             pixel_valid;
  logic             start_of_frame;
  logic [NL-1:0]    draw_req;
  logic [8*NL-1:0]  layer_rgb;
  logic [NL-1:0]    blink_en;
  logic [7:0]       background_rgb;

  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       v0, v1, ph0, ph1;
  logic [2:0] l0, l1;

  always #5 CLK = ~CLK;

  layer_compositor #(
    .NUM_LAYERS(NL), .TRANSPARENT(8'hFF), .BLINK_FRAMES(2), .REPLICATE(1'b0)
  ) dut_zp (
    .CLK(CLK), .RESET(RESET), .pixel_valid(pixel_valid),
    .start_of_frame(start_of_frame), .draw_req(draw_req),
    .layer_rgb(layer_rgb), .blink_en(blink_en),
    .background_rgb(background_rgb),
    .m_mVGA_R(r0), .m_mVGA_G(g0), .m_mVGA_B(b0),
    .out_valid(v0), .out_layer(l0), .blink_phase(ph0)
  );

  layer_compositor #(
    .NUM_LAYERS(NL), .TRANSPARENT(8'hFF), .BLINK_FRAMES(2), .REPLICATE(1'b1)
  ) dut_rep (
    .CLK(CLK), .RESET(RESET), .pixel_valid(pixel_valid),
    .start_of_frame(start_of_frame), .draw_req(draw_req),
    .layer_rgb(layer_rgb), .blink_en(blink_en),
    .background_rgb(background_rgb),
    .m_mVGA_R(r1), .m_mVGA_G(g1), .m_mVGA_B(b1),
    .out_valid(v1), .out_layer(l1), .blink_phase(ph1)
  );

  typedef struct packed {
    logic       valid;
    logic [2:0] layer;
    logic [7:0] c;
    logic       phase;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [23:0] expand(input logic [7:0] c, input bit rep);
    logic [7:0] r, g, b;
    if (rep) begin
      r = {c[7:5], c[7:5], c[7:6]};
      g = {c[4:2], c[4:2], c[4:3]};
      b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    end else begin
      r = {c[7:5], 5'b00000};
      g = {c[4:2], 5'b00000};
      b = {c[1:0], 6'b000000};
    end
    return {r, g, b};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Monitor: one output beat per cycle, compared on the falling edge.
  exp_t        e;
  logic [23:0] x0, x1;
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      e  = q.pop_front();
      x0 = expand(e.c, 1'b0);
      x1 = expand(e.c, 1'b1);
      check("valid_zp", {23'd0, v0},  {23'd0, e.valid});
      check("valid_rp", {23'd0, v1},  {23'd0, e.valid});
      check("layer_zp", {21'd0, l0},  {21'd0, e.layer});
      check("layer_rp", {21'd0, l1},  {21'd0, e.layer});
      check("phase_zp", {23'd0, ph0}, {23'd0, e.phase});
      check("phase_rp", {23'd0, ph1}, {23'd0, e.phase});
      check("rgb_zp",   {r0, g0, b0}, x0);
      check("rgb_rp",   {r1, g1, b1}, x1);
    end
  end

  // Drive one cycle of inputs. exp_c/exp_l describe the pixel two edges later;
  // exp_ph is the blink phase right after the coming edge.
  task automatic step(input logic pv, input logic sof, input logic [NL-1:0] req,
                      input logic [8*NL-1:0] rgb, input logic [NL-1:0] ben,
                      input logic [7:0] bg, input logic [7:0] exp_c,
                      input logic [2:0] exp_l, input logic exp_ph);
    exp_t t;
    RESET          = 1'b0;
    pixel_valid    = pv;
    start_of_frame = sof;
    draw_req       = req;
    layer_rgb      = rgb;
    blink_en       = ben;
    background_rgb = bg;
    t = q[q.size()-1];
    t.phase = exp_ph;
    q[q.size()-1] = t;
    t.valid = pv;
    t.layer = exp_l;
    t.c     = exp_c;
    t.phase = 1'b0;
    q.push_back(t);
    @(posedge CLK);
    #1;
  endtask

  // Reset cycle with random inputs: the output after this edge and the one
  // after it are both cleared.
  task automatic reset_step();
    exp_t z;
    z = '0;
    RESET          = 1'b1;
    pixel_valid    = 1'($urandom());
    start_of_frame = 1'($urandom());
    draw_req       = NL'($urandom());
    layer_rgb      = 40'({$urandom(), $urandom()});
    blink_en       = NL'($urandom());
    background_rgb = 8'($urandom());
    q[q.size()-1] = z;
    q.push_back(z);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [39:0] PRIO  = {8'hE0, 8'h00, 8'h03, 8'h00, 8'h1C};
  localparam logic [39:0] TRANS = {8'hFF, 8'h00, 8'h00, 8'h1C, 8'h00};
  localparam logic [39:0] BLNK  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h1C};
  localparam logic [39:0] EXPN  = {8'h00, 8'h00, 8'hAE, 8'h00, 8'h00};
  localparam logic [39:0] KEYED = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [39:0] BL3   = {8'h00, 8'hE0, 8'h00, 8'h00, 8'h00};

  // Blink schedule (half-period 2): shown/hidden per frame and cycle. The
  // first cycle of each frame carries start_of_frame and sees the old phase.
  bit shown_tab [6][3] = '{'{1,1,1}, '{1,1,1}, '{1,0,0},
                           '{0,0,0}, '{0,1,1}, '{1,1,1}};
  bit ph_tab    [6]    = '{0, 0, 1, 1, 0, 0};

  initial begin
    exp_t d;
    d = '0;
    q.push_back(d);

    repeat (3) reset_step();
    // Release: background only.
    step(1, 0, 5'b00000, '0, '0, 8'hE0, 8'hE0, 3'd5, 0);

    // Priority.
    step(1, 0, 5'b10101, PRIO, '0, 8'h00, 8'hE0, 3'd4, 0);
    step(1, 0, 5'b00101, PRIO, '0, 8'h00, 8'h03, 3'd2, 0);

    // Transparency key; keyed background passes through unchanged.
    step(1, 0, 5'b10010, TRANS, '0, 8'h00, 8'h1C, 3'd1, 0);
    step(1, 0, 5'b00000, TRANS, '0, 8'hFF, 8'hFF, 3'd5, 0);

    // Blanking: requests ignored while pixel_valid is low.
    step(1, 0, 5'b00001, BLNK, '0, 8'h00, 8'h1C, 3'd0, 0);
    step(0, 0, 5'b00001, BLNK, '0, 8'h00, 8'h00, 3'd5, 0);
    step(1, 0, 5'b00001, BLNK, '0, 8'h00, 8'h1C, 3'd0, 0);

    // Expansion of 8'b101_011_10.
    step(1, 0, 5'b00100, EXPN, '0, 8'h00, 8'hAE, 3'd2, 0);

    // All requesting layers keyed.
    step(1, 0, 5'b11111, KEYED, '0, 8'h49, 8'h49, 3'd5, 0);

    // Blink on layer 3 over six frames.
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < 3; j++) begin
        step(1, (f > 0 && j == 0), 5'b01000, BL3, 5'b01000, 8'h03,
             shown_tab[f][j] ? 8'hE0 : 8'h03,
             shown_tab[f][j] ? 3'd3 : 3'd5, ph_tab[f]);
      end
    end
    // Sixth pulse hides layer 3 again, then a mid-frame reset restores phase 0.
    step(1, 1, 5'b01000, BL3, 5'b01000, 8'h03, 8'hE0, 3'd3, 1);
    step(1, 0, 5'b01000, BL3, 5'b01000, 8'h03, 8'h03, 3'd5, 1);
    reset_step();
    step(1, 0, 5'b01000, BL3, 5'b01000, 8'h03, 8'hE0, 3'd3, 0);
    step(1, 0, 5'b01000, BL3, 5'b01000, 8'h03, 8'hE0, 3'd3, 0);
    step(0, 0, 5'b01000, BL3, 5'b01000, 8'h03, 8'h00, 3'd5, 0);
    step(0, 0, 5'b00000, '0,  '0,       8'h00, 8'h00, 3'd5, 0);

    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
